// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 types, GF(2^8) helpers, key schedule steps and FSM states
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_DONE
  } state_e;

  function automatic byte_t rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte 0 of a block sits in [127:120], so FIPS hex strings read left to right.
  function automatic byte_t get_byte(input block_t b, input int i);
    return byte_t'(b >> (8 * (15 - i)));
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254; maps 0 to 0 as the S-box requires.
  function automatic byte_t gf_inv(input byte_t b);
    byte_t sq, r;
    sq = b;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic byte_t rotl(input byte_t b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic byte_t sbox(input byte_t b);
    byte_t i;
    i = gf_inv(b);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(input byte_t b);
    return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic word_t sub_rot_word(input word_t w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic block_t key_fwd(input block_t rk, input byte_t rc);
    word_t w0, w1, w2, w3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic block_t key_bwd(input block_t rk, input byte_t rc);
    word_t w0, w1, w2, w3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/inv_cipher_if.sv
// rtl/inv_cipher_if.sv - request/response handshake bundle for the AES-128 decryptor
interface inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         key_hit;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext, key_hit
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext, key_hit
  );
endinterface

// File: rtl/inv_round.sv
// rtl/inv_round.sv - one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module inv_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rk_i,
  input  logic   last_i,
  output block_t state_o
);

  block_t sub, ark, mix;
  byte_t  a0, a1, a2, a3;
  byte_t  m0, m1, m2, m3;

  always_comb begin
    sub = '0;
    mix = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    m0  = '0;
    m1  = '0;
    m2  = '0;
    m3  = '0;
    // Row r of column c takes the byte that sat r columns to its left.
    for (int i = 0; i < 16; i++) begin
      sub = sub | (block_t'(inv_sbox(get_byte(state_i, (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4))))
                   << (8 * (15 - i)));
    end
    ark = sub ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(ark, 4 * c);
      a1 = get_byte(ark, 4 * c + 1);
      a2 = get_byte(ark, 4 * c + 2);
      a3 = get_byte(ark, 4 * c + 3);
      m0 = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      m1 = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      m2 = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      m3 = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
      mix = mix | (block_t'({m0, m1, m2, m3}) << (32 * (3 - c)));
    end
  end

  assign state_o = last_i ? ark : mix;

endmodule

// File: rtl/inv_cipher.sv
// rtl/inv_cipher.sv - iterative AES-128 decryptor, one round per clock, with last-key cache
module inv_cipher
  import aes_pkg::*;
#(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  inv_cipher_if.slave  bus
);

  state_e     state_q;
  logic [3:0] cnt_q;
  block_t     data_q, rk_q, key_in_q, cached_key_q, cached_rk10_q, pt_q;
  logic       cache_valid_q, hit_q, key_hit_q, out_valid_q, in_ready_q;

  block_t     round_d, rk_fwd_d, rk_bwd_d;
  logic       hit_d;

  assign hit_d    = (KEY_CACHE != 0) && cache_valid_q && (bus.key == cached_key_q);
  assign rk_fwd_d = key_fwd(rk_q, rcon(cnt_q));
  assign rk_bwd_d = key_bwd(rk_q, rcon(cnt_q));

  inv_round u_round (
    .state_i (data_q),
    .rk_i    (rk_bwd_d),
    .last_i  (cnt_q == 4'd1),
    .state_o (round_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      data_q        <= '0;
      rk_q          <= '0;
      key_in_q      <= '0;
      cached_key_q  <= '0;
      cached_rk10_q <= '0;
      pt_q          <= '0;
      cache_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      key_hit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.ciphertext;
            key_in_q   <= bus.key;
            hit_q      <= hit_d;
            in_ready_q <= 1'b0;
            if (hit_d) begin
              rk_q    <= cached_rk10_q;
              state_q <= ST_INIT;
            end else begin
              rk_q    <= bus.key;
              cnt_q   <= 4'd1;
              state_q <= ST_KEYEXP;
            end
          end
        end
        ST_KEYEXP: begin
          rk_q  <= rk_fwd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            cached_key_q  <= key_in_q;
            cached_rk10_q <= rk_fwd_d;
            cache_valid_q <= 1'b1;
            state_q       <= ST_INIT;
          end
        end
        ST_INIT: begin
          data_q  <= data_q ^ rk_q;
          cnt_q   <= 4'd10;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          // The key walks backwards alongside the data, so rk0 is reached on the last round.
          data_q <= round_d;
          rk_q   <= rk_bwd_d;
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pt_q        <= round_d;
            out_valid_q <= 1'b1;
            key_hit_q   <= hit_q;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = pt_q;
  assign bus.key_hit   = key_hit_q;

endmodule

// File: tb/tb_inv_cipher.sv
// tb/tb_inv_cipher.sv - directed FIPS-197 vectors and handshake corner cases for inv_cipher
module tb_inv_cipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    logic         hit;
    int           lat;
    logic         sel;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  int           n_tests = 0;
  int           n_fail = 0;
  int           lat;
  vec_t         vecs [7];

  always #5 clk = ~clk;

  inv_cipher_if bus_c ();
  inv_cipher_if bus_n ();

  inv_cipher #(.KEY_CACHE(1)) dut_c (.clk(clk), .reset(rst), .bus(bus_c));
  inv_cipher #(.KEY_CACHE(0)) dut_n (.clk(clk), .reset(rst), .bus(bus_n));

  assign bus_c.in_valid   = in_valid & ~sel;
  assign bus_n.in_valid   = in_valid & sel;
  assign bus_c.out_ready  = out_ready & ~sel;
  assign bus_n.out_ready  = out_ready & sel;
  assign bus_c.ciphertext = ciphertext;
  assign bus_n.ciphertext = ciphertext;
  assign bus_c.key        = key;
  assign bus_n.key        = key;

  logic         in_ready_m, out_valid_m, key_hit_m;
  logic [127:0] pt_m;
  assign in_ready_m  = sel ? bus_n.in_ready  : bus_c.in_ready;
  assign out_valid_m = sel ? bus_n.out_valid : bus_c.out_valid;
  assign key_hit_m   = sel ? bus_n.key_hit   : bus_c.key_hit;
  assign pt_m        = sel ? bus_n.plaintext : bus_c.plaintext;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [127:0] c, input logic [127:0] k, input bit scramble,
                         output int l);
    int guard;
    guard = 0;
    while (!in_ready_m && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready before request", 128'(in_ready_m), 128'd1);
    in_valid   = 1'b1;
    ciphertext = c;
    key        = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid_m && l < 40) begin
      if (scramble) begin
        in_valid   = ~in_valid;
        ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
        key        = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(posedge clk); #1;
      l++;
    end
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ct: C1_CT, key: C1_KEY, pt: C1_PT,  hit: 1'b0, lat: 21, sel: 1'b0};
    vecs[1] = '{ct: C1_CT, key: C1_KEY, pt: C1_PT,  hit: 1'b1, lat: 11, sel: 1'b0};
    vecs[2] = '{ct: Z_CT,  key: '0,     pt: '0,     hit: 1'b0, lat: 21, sel: 1'b0};
    vecs[3] = '{ct: B_CT,  key: B_KEY,  pt: B_PT,   hit: 1'b0, lat: 21, sel: 1'b0};
    vecs[4] = '{ct: B_CT,  key: B_KEY,  pt: B_PT,   hit: 1'b1, lat: 11, sel: 1'b0};
    vecs[5] = '{ct: C1_CT, key: C1_KEY, pt: C1_PT,  hit: 1'b0, lat: 21, sel: 1'b1};
    vecs[6] = '{ct: C1_CT, key: C1_KEY, pt: C1_PT,  hit: 1'b0, lat: 21, sel: 1'b1};

    rst        = 1'b1;
    sel        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset in_ready",  128'(bus_c.in_ready),  128'd1);
    check("reset out_valid", 128'(bus_c.out_valid), 128'd0);
    check("reset plaintext", bus_c.plaintext,       128'd0);
    check("reset key_hit",   128'(bus_c.key_hit),   128'd0);
    check("reset in_ready nocache", 128'(bus_n.in_ready), 128'd1);

    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel;
      run_req(vecs[i].ct, vecs[i].key, 1'b0, lat);
      check($sformatf("vec%0d plaintext", i), pt_m, vecs[i].pt);
      check($sformatf("vec%0d key_hit", i), 128'(key_hit_m), 128'(vecs[i].hit));
      check($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      accept();
    end
    sel = 1'b0;

    // Back-pressure: cache holds the B key, so this is a hit.
    run_req(B_CT, B_KEY, 1'b0, lat);
    check("hold latency", 128'(lat), 128'd11);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d out_valid", k), 128'(out_valid_m), 128'd1);
      check($sformatf("hold%0d plaintext", k), pt_m, B_PT);
      check($sformatf("hold%0d in_ready", k), 128'(in_ready_m), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release out_valid", 128'(out_valid_m), 128'd0);
    check("release in_ready",  128'(in_ready_m),  128'd1);

    // Reset while the round counter sits at 5 (16 edges after a miss accept).
    in_valid   = 1'b1;
    ciphertext = C1_CT;
    key        = C1_KEY;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset out_valid", 128'(out_valid_m), 128'd0);
    check("midreset plaintext", pt_m,              128'd0);
    check("midreset in_ready",  128'(in_ready_m),  128'd1);
    run_req(C1_CT, C1_KEY, 1'b0, lat);
    check("post-reset plaintext", pt_m,             C1_PT);
    check("post-reset key_hit",   128'(key_hit_m),  128'd0);
    check("post-reset latency",   128'(lat),        128'd21);
    accept();

    // Busy-time input changes must not disturb the accepted request.
    run_req(Z_CT, '0, 1'b1, lat);
    check("scramble plaintext", pt_m,            128'd0);
    check("scramble key_hit",   128'(key_hit_m), 128'd0);
    check("scramble latency",   128'(lat),       128'd21);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
